// File: rtl/fetch_align_queue.sv
// Fetch realignment queue: buffers I-cache words as halfwords, issues aligned instructions.
// Compressed (16-bit) instruction support is enabled by defining FETCH_ALIGN_RVC_EN.
module fetch_align_queue #(
    parameter int unsigned DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        fetch_req_o,
    output logic [29:0]                 fetch_addr_o,
    input  logic                        fetch_stall_i,
    input  logic [31:0]                 fetch_rdata_i,
    input  logic                        redirect_i,
    input  logic [31:0]                 redirect_pc_i,
    output logic                        inst_valid_o,
    input  logic                        inst_ready_i,
    output logic [31:0]                 inst_o,
    output logic [31:0]                 inst_pc_o,
    output logic                        inst_compressed_o,
    output logic [$clog2(DEPTH_HW):0]   occupancy_o
);

    localparam int unsigned PW = $clog2(DEPTH_HW);

`ifdef FETCH_ALIGN_RVC_EN
    localparam logic RVC = 1'b1;
`else
    localparam logic RVC = 1'b0;
`endif

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    // Without RVC every target is word aligned, so PC[1] is dropped.
    localparam logic [31:0] RST_PC_EFF = RVC ? {RESET_PC[31:1], 1'b0}
                                             : {RESET_PC[31:2], 2'b00};
    localparam logic        RST_DROP   = RVC & RESET_PC[1];

    logic [15:0] mem [DEPTH_HW];
    ptr_t        head_q;
    ptr_t        tail_q;
    cnt_t        count_q;
    logic [29:0] addr_q;
    logic        drop_q;
    logic [31:0] pc_q;

    logic [15:0] h0;
    logic [15:0] h1;
    logic        need2;
    cnt_t        free;
    logic        accept;
    logic        push;
    logic        pop;
    cnt_t        n_push;
    cnt_t        n_pop;
    logic [31:0] redir_pc;
    logic        redir_drop;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc_i[1:0];

    assign h0    = mem[head_q];
    assign h1    = mem[head_q + ptr_t'(1)];
    assign need2 = !RVC || (h0[1:0] == 2'b11);
    assign free  = cnt_t'(DEPTH_HW) - count_q;

    assign fetch_req_o  = !rst && (free >= (drop_q ? cnt_t'(1) : cnt_t'(2)));
    assign fetch_addr_o = addr_q;

    assign inst_valid_o      = need2 ? (count_q >= cnt_t'(2)) : (count_q != '0);
    assign inst_o            = need2 ? {h1, h0} : {16'h0000, h0};
    assign inst_compressed_o = RVC && (h0[1:0] != 2'b11);
    assign inst_pc_o         = pc_q;
    assign occupancy_o       = count_q;

    // Redirect squashes both the returning word and any handshake.
    assign accept = fetch_req_o && !fetch_stall_i;
    assign push   = accept && !redirect_i;
    assign pop    = inst_valid_o && inst_ready_i && !redirect_i;
    assign n_push = push ? (drop_q ? cnt_t'(1) : cnt_t'(2)) : cnt_t'(0);
    assign n_pop  = pop ? (need2 ? cnt_t'(2) : cnt_t'(1)) : cnt_t'(0);

    assign redir_pc   = RVC ? {redirect_pc_i[31:1], 1'b0}
                            : {redirect_pc_i[31:2], 2'b00};
    assign redir_drop = RVC & redirect_pc_i[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= RESET_PC[31:2];
            drop_q  <= RST_DROP;
            pc_q    <= RST_PC_EFF;
        end else if (redirect_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= redirect_pc_i[31:2];
            drop_q  <= redir_drop;
            pc_q    <= redir_pc;
        end else begin
            if (push) begin
                addr_q <= addr_q + 30'd1;
                drop_q <= 1'b0;
                tail_q <= tail_q + ptr_t'(n_push);
            end
            if (pop) begin
                head_q <= head_q + ptr_t'(n_pop);
                pc_q   <= pc_q + (need2 ? 32'd4 : 32'd2);
            end
            count_q <= count_q + n_push - n_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            if (drop_q) begin
                mem[tail_q] <= fetch_rdata_i[31:16];
            end else begin
                mem[tail_q]               <= fetch_rdata_i[15:0];
                mem[tail_q + ptr_t'(1)]   <= fetch_rdata_i[31:16];
            end
        end
    end

endmodule

// File: doc/fetch_align_queue.md
Name: fetch_align_queue

Overview:
- Parametrised fetch/realignment queue between the I-cache and the IF/ID register; replaces the fixed one-halfword compression buffer and its three-state (complete/incomplete/prepare) tracker.
- Stores fetched 32-bit words as a circular queue of halfwords and presents one aligned instruction (16- or 32-bit) per cycle with its PC.
- Handles 32-bit instructions that straddle a word boundary, and redirects to halfword-aligned targets.
- Uses valid/ready on the decode side and is driven by stall on the cache side.

Parameters:
- DEPTH_HW, 8: queue depth in halfwords; power of two, minimum 4.
- RESET_PC, 32'h0000_0000: PC after reset; bit 0 must be 0.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- fetch_req_o  out  1  word fetch request to I-cache
- fetch_addr_o  out  30  word address, PC[31:2]
- fetch_stall_i  in  1  cache busy; a word is accepted when fetch_req_o && !fetch_stall_i
- fetch_rdata_i  in  32  fetched word, already little-endian; [15:0] is the lower-address halfword
- redirect_i  in  1  flush and restart (branch mispredict, jal, jalr)
- redirect_pc_i  in  32  restart PC; bit 0 ignored
- inst_valid_o  out  1  aligned instruction available
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  instruction; for compressed, {16'h0, halfword}
- inst_pc_o  out  32  PC of inst_o
- inst_compressed_o  out  1  inst_o[1:0] != 2'b11
- occupancy_o  out  $clog2(DEPTH_HW)+1  halfwords held

Behaviour:
- Reset: while rst=1, fetch_req_o=0. On the clock edge with rst=1:
  - count=0, head/tail pointers=0
  - fetch_addr register = RESET_PC[31:2]
  - drop_first = RESET_PC[1]
  - inst_pc register = RESET_PC
  - inst_valid_o=0 from the next cycle.
- Fetch request: fetch_req_o = !rst && free >= (drop_first ? 1 : 2), where free = DEPTH_HW - count.
  - At most one word outstanding; the address stays stable while stalled.
- Word accept: on accept, fetch_addr increments by 1, with wrap-around modulo 2^30.
  - If drop_first=1, push only fetch_rdata_i[31:16] and clear drop_first.
  - Otherwise push [15:0] then [31:16].
- Instruction presentation is combinational from the queue head h0:
  - If h0[1:0] != 2'b11: needs 1 halfword; inst_o = {16'h0, h0}.
  - Otherwise: needs 2 halfwords; inst_o = {h1, h0}.
  - inst_valid_o = (count >= needed).
  - A partial 32-bit instruction (count=1, h0[1:0]=11) holds inst_valid_o=0 until its upper half arrives.
- Pop: on inst_valid_o && inst_ready_i, the head advances by needed and inst_pc advances by 2 or 4.
- Simultaneous push and pop in one cycle is legal: count_next = count + pushed - popped.
  - Full queue: no request is made; no overflow is possible by construction.
  - Empty queue: inst_valid_o=0.
  - Pointers wrap modulo DEPTH_HW.
- Redirect has the highest priority. In the cycle redirect_i=1:
  - Any accepted word and any pop handshake are discarded.
  - Next state: count=0; fetch_addr = redirect_pc_i[31:2]; drop_first = redirect_pc_i[1]; inst_pc = {redirect_pc_i[31:1], 1'b0}.
  - inst_valid_o is 0 the following cycle.
  - Earliest valid instruction is 2 cycles after redirect, given no stall.
- rst asserted mid-operation behaves like a redirect to RESET_PC; queued data is lost.
- Latency: word accepted at edge N; its instruction is valid in cycle N+1 (registered queue).
- Throughput: sustained 1 instruction/cycle for any 16/32 mix when the cache does not stall.

Optional Feature:
- Macro FETCH_ALIGN_RVC_EN.
- Defined: full compressed support as above.
- Undefined:
  - Every instruction is treated as 32-bit; needed = 2 always; inst_compressed_o tied 0.
  - redirect_pc_i[1] and RESET_PC[1] are ignored (drop_first is always 0).
  - inst_pc always advances by 4.
  - Halfword-granular storage remains, so there is no port change.

Test Plan:
1. Reset with RESET_PC=0, then words 0x00A00093 and 0x00000013, no stall -> cycle after each accept: inst_o=0x00A00093 at PC 0, then 0x00000013 at PC 4; inst_compressed_o=0.
2. Word 0x4505_0085 (c.addi then c.li) -> two instructions: inst_o=0x00000085 at PC 0, then 0x00004505 at PC 2; both compressed.
3. Straddle:
   - Words 0x0093_4505 then 0x1234_00A0.
   - Expect 0x4505 at PC 0, then 32-bit 0x00A00093 at PC 2, with valid held low until the second word is accepted.
   - Then 0x1234 at PC 6.
4. Redirect to 0x0000_0102 while the queue holds 4 halfwords -> next cycle: occupancy_o=0, fetch_addr_o=0x40, inst_valid_o=0; the returned word's [15:0] is dropped, and the first instruction has inst_pc_o=0x102.
5. inst_ready_i=0 for 10 cycles with DEPTH_HW=8 -> fetch_req_o drops when occupancy reaches 8 (7 if drop_first). Then hold fetch_stall_i=1 for 5 cycles while popping: fetch_addr_o stays stable, no data is lost, and the PC sequence is continuous.
6. Redirect and a pop handshake in the same cycle, with an accepted word -> pop and word both discarded; inst_pc_o equals the redirect target two cycles later.
